ysyx_23060072_pc_gen: RTL and testbench

Fetch-address generator that sits directly upstream of the instruction fetch unit. It drives the PC the IFU reads through its 32-bit instruction address input.
- Holds the architectural fetch PC and advances it by 4 per accepted instruction.
- Applies redirects from EX/CSR: branch/jump, trap entry, mret.
- Honours the hazard-unit stall.
- Presents a valid/ready handshake to the IF/ID boundary.
- Enters a halt state on ebreak for simulation termination.

---
 rtl/ysyx_23060072_pc_gen.sv | 88 ++++++++
 tb/tb_ysyx_23060072_pc_gen.sv | 133 +++++++++++++
 2 files changed

// File: rtl/ysyx_23060072_pc_gen.sv
// ysyx_23060072_pc_gen: fetch PC generator with redirects, stall, valid/ready and ebreak halt.
// Optional YSYX_23060072_PC_MISALIGN_CHECK_EN drops misaligned redirects and reports them.
module ysyx_23060072_pc_gen #(
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter logic [31:0] PC_INC    = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        pc_ready_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        trap_i,
  input  logic [31:0] trap_vec_i,
  input  logic        mret_i,
  input  logic [31:0] mepc_i,
  input  logic        ebreak_i,
  output logic [31:0] pc_o,
  output logic        pc_valid_o,
  output logic        flush_o,
  output logic        halted_o,
  output logic        misalign_o,
  output logic [31:0] misalign_addr_o
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_valid;
  logic        r_flush;
  logic        r_halted;
  logic        w_redir;
  logic        w_mis;
  logic [31:0] w_target;
  logic [31:0] w_tgt;
  assign w_redir  = trap_i | mret_i | br_taken_i;
  assign w_target = trap_i ? trap_vec_i : mret_i ? mepc_i : br_target_i;
  assign w_tgt    = w_target & ~32'h3;
`ifdef YSYX_23060072_PC_MISALIGN_CHECK_EN
  logic        r_mis;
  logic [31:0] r_mis_addr;
  logic        w_take;
  assign w_mis  = w_target[1:0] != 2'b00;
  assign w_take = (r_state == RUN) && !ebreak_i && w_redir;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_mis      <= 1'b0;
      r_mis_addr <= '0;
    end else begin
      r_mis <= w_take && w_mis;
      if (w_take && w_mis) r_mis_addr <= w_target;
    end
  assign misalign_o      = r_mis;
  assign misalign_addr_o = r_mis_addr;
`else
  assign w_mis           = 1'b0;
  assign misalign_o      = 1'b0;
  assign misalign_addr_o = '0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= BOOT;
      r_pc     <= RESET_VEC;
      r_valid  <= 1'b0;
      r_flush  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_flush <= 1'b0;
      if (r_state == BOOT) begin
        r_state <= RUN;
        r_valid <= 1'b1;
      end else if (r_state == RUN) begin
        if (ebreak_i) begin
          r_state  <= HALT;
          r_valid  <= 1'b0;
          r_halted <= 1'b1;
        end else if (w_redir) begin
          if (!w_mis) begin
            r_pc    <= w_tgt;
            r_flush <= 1'b1;
          end
        end else if (!stall_i && r_valid && pc_ready_i) r_pc <= r_pc + PC_INC;
      end
    end
  assign pc_o       = r_pc;
  assign pc_valid_o = r_valid;
  assign flush_o    = r_flush;
  assign halted_o   = r_halted;
endmodule

// File: tb/tb_ysyx_23060072_pc_gen.sv
// tb_ysyx_23060072_pc_gen: scoreboard bench; stimulus queues per-cycle expectations, monitor checks at negedge.
module tb_ysyx_23060072_pc_gen;
`ifdef YSYX_23060072_PC_MISALIGN_CHECK_EN
  localparam bit MC = 1'b1;
`else
  localparam bit MC = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n, stall_i, pc_ready_i, br_taken_i, trap_i, mret_i, ebreak_i;
  logic [31:0] br_target_i, trap_vec_i, mepc_i;
  logic [31:0] pc_o, misalign_addr_o;
  logic        pc_valid_o, flush_o, halted_o, misalign_o;
  typedef struct {
    int          t;
    int          id;
    logic [31:0] pc;
    logic        v, f, h, m;
    logic [31:0] ma;
  } exp_t;
  exp_t q[$];
  int cyc = 0, n_cmp = 0, n_bad = 0, n_id = 0;
  ysyx_23060072_pc_gen dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .pc_ready_i(pc_ready_i),
    .br_taken_i(br_taken_i), .br_target_i(br_target_i), .trap_i(trap_i),
    .trap_vec_i(trap_vec_i), .mret_i(mret_i), .mepc_i(mepc_i), .ebreak_i(ebreak_i),
    .pc_o(pc_o), .pc_valid_o(pc_valid_o), .flush_o(flush_o), .halted_o(halted_o),
    .misalign_o(misalign_o), .misalign_addr_o(misalign_addr_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input exp_t e);
    n_cmp++;
    if (pc_o !== e.pc || pc_valid_o !== e.v || flush_o !== e.f || halted_o !== e.h ||
        misalign_o !== e.m || misalign_addr_o !== e.ma) begin
      n_bad++;
      $display("FAIL step%0d: got pc=%h v=%b f=%b h=%b m=%b ma=%h, want pc=%h v=%b f=%b h=%b m=%b ma=%h",
               e.id, pc_o, pc_valid_o, flush_o, halted_o, misalign_o, misalign_addr_o,
               e.pc, e.v, e.f, e.h, e.m, e.ma);
    end
  endtask
  always @(negedge clk)
    while (q.size() > 0 && q[0].t <= cyc) check(q.pop_front());
  // Queue the expected outputs after the coming edge, then advance past it.
  task automatic step(input logic [31:0] pc, input logic v, f, h, m, input logic [31:0] ma);
    exp_t e;
    e = '{t: cyc + 1, id: n_id++, pc: pc, v: v, f: f, h: h, m: m, ma: ma};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [31:0] pc, input logic f = 1'b0);
    step(pc, 1'b1, f, 1'b0, 1'b0, 32'h0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    exp_t e;
    rst_n = 1'b0; stall_i = 0; pc_ready_i = 1; br_taken_i = 0; trap_i = 0; mret_i = 0; ebreak_i = 0;
    br_target_i = 0; trap_vec_i = 0; mepc_i = 0;
    repeat (2) @(posedge clk);
    #1;
    e = '{t: 0, id: -1, pc: 32'h8000_0000, v: 0, f: 0, h: 0, m: 0, ma: 0};
    check(e);
    rst_n = 1'b1;
    run(32'h8000_0000);
    run(32'h8000_0004); run(32'h8000_0008); run(32'h8000_000C); run(32'h8000_0010);
    stall_i = 1;
    repeat (3) run(32'h8000_0010);
    stall_i = 0;
    run(32'h8000_0014);
    pc_ready_i = 0;
    repeat (3) run(32'h8000_0014);
    pc_ready_i = 1;
    run(32'h8000_0018); run(32'h8000_001C); run(32'h8000_0020);
    br_taken_i = 1; br_target_i = 32'h8000_0100; stall_i = 1;
    run(32'h8000_0100, 1);
    br_taken_i = 0; stall_i = 0;
    run(32'h8000_0104);
    trap_i = 1; trap_vec_i = 32'h8000_0200; mret_i = 1; mepc_i = 32'h8000_0300;
    br_taken_i = 1; br_target_i = 32'h8000_0500;
    run(32'h8000_0200, 1);
    trap_i = 0; mret_i = 0; br_taken_i = 0;
    run(32'h8000_0204);
    br_taken_i = 1; br_target_i = 32'h8000_0400;
    run(32'h8000_0400, 1);
    br_target_i = 32'h8000_0600;
    run(32'h8000_0600, 1);
    br_taken_i = 0;
    run(32'h8000_0604);
    mret_i = 1; pc_ready_i = 0;
    run(32'h8000_0300, 1);
    mret_i = 0; pc_ready_i = 1;
    run(32'h8000_0304);
    br_taken_i = 1; br_target_i = 32'hFFFF_FFFC;
    run(32'hFFFF_FFFC, 1);
    br_taken_i = 0;
    run(32'h0000_0000);
    run(32'h0000_0004);
    br_taken_i = 1; br_target_i = 32'h8000_0102;
    step(MC ? 32'h4 : 32'h8000_0100, 1, !MC, 0, MC, MC ? 32'h8000_0102 : 32'h0);
    br_taken_i = 0;
    step(MC ? 32'h8 : 32'h8000_0104, 1, 0, 0, 0, MC ? 32'h8000_0102 : 32'h0);
    trap_i = 1; trap_vec_i = 32'h8000_0201; br_taken_i = 1; br_target_i = 32'h8000_0400;
    step(MC ? 32'h8 : 32'h8000_0200, 1, !MC, 0, MC, MC ? 32'h8000_0201 : 32'h0);
    trap_i = 0; br_taken_i = 0; stall_i = 1;
    step(MC ? 32'h8 : 32'h8000_0200, 1, 0, 0, 0, MC ? 32'h8000_0201 : 32'h0);
    stall_i = 0; br_taken_i = 1; br_target_i = 32'h8000_1000;
    step(32'h8000_1000, 1, 1, 0, 0, MC ? 32'h8000_0201 : 32'h0);
    br_taken_i = 0; ebreak_i = 1;
    step(32'h8000_1000, 0, 0, 1, 0, MC ? 32'h8000_0201 : 32'h0);
    ebreak_i = 0; br_taken_i = 1; br_target_i = 32'h8000_2000; trap_i = 1; trap_vec_i = 32'h8000_3003;
    step(32'h8000_1000, 0, 0, 1, 0, MC ? 32'h8000_0201 : 32'h0);
    step(32'h8000_1000, 0, 0, 1, 0, MC ? 32'h8000_0201 : 32'h0);
    br_taken_i = 0; trap_i = 0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    e = '{t: 0, id: -2, pc: 32'h8000_0000, v: 0, f: 0, h: 0, m: 0, ma: 0};
    check(e);
    #10;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
